// File: rtl/i_cache_pkg.sv
// Shared constants and controller state type for the fetch-side
// instruction cache.
package i_cache_pkg;

    localparam int WORD_SIZE        = 32;
    localparam int ICACHE_LINE_SIZE = 128;

    localparam logic [WORD_SIZE-1:0] NOP        = 32'h00000013;
    localparam logic [WORD_SIZE-1:0] PC_INITIAL = 32'h00000000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FILL
    } cacheState_t;

endpackage

// File: rtl/i_cache_instruction_memory.sv
// Backing instruction store: returns a whole cache line a fixed
// number of cycles after a read request, one request at a time.
module instruction_memory
    import i_cache_pkg::*;
#(
    parameter int LINE_WORDS  = 4,
    parameter int MEM_WORDS   = 4096,
    parameter int MEM_LATENCY = 5,
    parameter     INIT_FILE   = "imem.hex"
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [WORD_SIZE-1:0]            addr,
    input  logic                            read,
    output logic [LINE_WORDS*WORD_SIZE-1:0] line,
    output logic                            ready
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(MEM_LATENCY + 1);

    logic [WORD_SIZE-1:0] mem [MEM_WORDS];

    logic          busy;
    logic [CW-1:0] cnt;
    logic [AW-1:0] baseWord;
    logic          lineLoad;
    logic          unusedAddrBits;

    // Only the word index bits select storage; the rest wrap away.
    assign unusedAddrBits = ^{addr[WORD_SIZE-1:AW+2], addr[1:0]};

    // The request cycle counts as cycle 1, so cnt starts at 2 on the
    // first busy cycle and ready lands in cycle MEM_LATENCY.
    assign lineLoad = busy && (cnt == CW'(MEM_LATENCY - 1));

    // Request acceptance and latency counter; reads while busy are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            cnt      <= '0;
            ready    <= 1'b0;
            baseWord <= '0;
        end else begin
            ready <= 1'b0;
            if (busy) begin
                if (lineLoad) begin
                    busy  <= 1'b0;
                    cnt   <= '0;
                    ready <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (read) begin
                busy     <= 1'b1;
                cnt      <= CW'(2);
                baseWord <= addr[AW+1:2];
            end
        end
    end

    // Line register, loaded with ready and held until the next completion.
    always_ff @(posedge clk) begin
        if (lineLoad) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                line[k*WORD_SIZE +: WORD_SIZE] <= mem[baseWord + AW'(k)];
            end
        end
    end

endmodule

// File: rtl/i_cache.sv
// Direct-mapped read-only instruction cache with refill controller
// and the fetch PC+4 adder.
module i_cache
    import i_cache_pkg::*;
#(
    parameter int LINE_WORDS  = 4,
    parameter int NUM_LINES   = 4,
    parameter int MEM_WORDS   = 4096,
    parameter int MEM_LATENCY = 5,
    parameter     INIT_FILE   = "imem.hex"
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] pc,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] pc_plus4,
    output logic                 cache_stall
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_LO = 2 + OFF_W + IDX_W;
    localparam int TAG_W  = WORD_SIZE - TAG_LO;
    localparam int LINE_W = LINE_WORDS * WORD_SIZE;

    logic [WORD_SIZE-1:0] dataArr [NUM_LINES][LINE_WORDS];
    logic [TAG_W-1:0]     tagArr  [NUM_LINES];
    logic [NUM_LINES-1:0] validArr;

    cacheState_t          state;
    logic [WORD_SIZE-1:0] lineAddr;
    logic                 memRead;
    logic [LINE_W-1:0]    memLine;
    logic                 memReady;

    logic [OFF_W-1:0] pcOff;
    logic [IDX_W-1:0] pcIdx;
    logic [TAG_W-1:0] pcTag;
    logic [IDX_W-1:0] fillIdx;
    logic [TAG_W-1:0] fillTag;
    logic             hit;

    assign pcOff   = pc[OFF_W+1:2];
    assign pcIdx   = pc[TAG_LO-1:OFF_W+2];
    assign pcTag   = pc[WORD_SIZE-1:TAG_LO];
    assign fillIdx = lineAddr[TAG_LO-1:OFF_W+2];
    assign fillTag = lineAddr[WORD_SIZE-1:TAG_LO];

    assign hit = validArr[pcIdx] && (tagArr[pcIdx] == pcTag);

    assign pc_plus4    = pc + 32'd4;
    assign cache_stall = !hit;
    assign instr       = hit ? dataArr[pcIdx][pcOff] : NOP;

    instruction_memory #(
        .LINE_WORDS  (LINE_WORDS),
        .MEM_WORDS   (MEM_WORDS),
        .MEM_LATENCY (MEM_LATENCY),
        .INIT_FILE   (INIT_FILE)
    ) uMem (
        .clk   (clk),
        .rst   (rst),
        .addr  (lineAddr),
        .read  (memRead),
        .line  (memLine),
        .ready (memReady)
    );

    // Refill controller; the latched line address keeps an in-flight
    // fill on its original index/tag even if pc is redirected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            memRead  <= 1'b0;
            lineAddr <= PC_INITIAL;
            validArr <= '0;
        end else begin
            memRead <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!hit) begin
                        lineAddr <= {pc[WORD_SIZE-1:OFF_W+2], {(OFF_W+2){1'b0}}};
                        memRead  <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (memReady) state <= FILL;
                end
                FILL: begin
                    validArr[fillIdx] <= 1'b1;
                    state             <= IDLE;
                end
            endcase
        end
    end

    // Line storage: tag and words captured from the returned memory line.
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            tagArr[fillIdx] <= fillTag;
            for (int k = 0; k < LINE_WORDS; k++) begin
                dataArr[fillIdx][k] <= memLine[k*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

endmodule

// File: tb/tb_i_cache.sv
// Self-checking bench for i_cache: directed boundary cases followed by
// randomized fetch streams against a behavioural cache model.
module tb_i_cache;

    localparam int LAT      = 5;
    localparam int MISS_CYC = LAT + 2;
    localparam int MW       = 4096;
    localparam logic [31:0] NOPW = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc  = 32'h0;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        cache_stall;

    i_cache #(
        .LINE_WORDS  (4),
        .NUM_LINES   (4),
        .MEM_WORDS   (MW),
        .MEM_LATENCY (LAT),
        .INIT_FILE   ("")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .instr       (instr),
        .pc_plus4    (pc_plus4),
        .cache_stall (cache_stall)
    );

    always #5 clk = ~clk;

    logic [31:0] img [MW];

    // Model: which line each slot holds, and a pending fill countdown.
    bit          mValid [4];
    logic [25:0] mTag   [4];
    bit          mBusy = 1'b0;
    int          mLeft = 0;
    logic [31:0] mFillPc = 32'h0;

    int nChecks = 0;
    int nFail   = 0;

    logic [25:0] tagPool [4] = '{26'h0, 26'h1, 26'h2, 26'h3FFFFFF};

    function automatic int lineIdx(input logic [31:0] a);
        return int'((a >> 4) % 4);
    endfunction

    function automatic bit mHit(input logic [31:0] a);
        return mValid[lineIdx(a)] && (mTag[lineIdx(a)] == a[31:6]);
    endfunction

    function automatic logic [31:0] randPc();
        logic [31:0] v;
        v = {tagPool[$urandom_range(0, 3)], 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 2'b00};
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A miss seen while idle starts a fill that installs MISS_CYC edges later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) mValid[i] = 1'b0;
            mBusy = 1'b0;
            mLeft = 0;
        end else if (mBusy) begin
            mLeft--;
            if (mLeft == 0) begin
                mValid[lineIdx(mFillPc)] = 1'b1;
                mTag[lineIdx(mFillPc)]   = mFillPc[31:6];
                mBusy = 1'b0;
            end
        end else if (!mHit(pc)) begin
            mBusy   = 1'b1;
            mLeft   = MISS_CYC - 1;
            mFillPc = pc;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic        expStall;
        logic [31:0] expInstr;
        expStall = !mHit(pc);
        expInstr = expStall ? NOPW : img[int'((pc >> 2) % MW)];
        check("cyc_stall", 32'(cache_stall), 32'(expStall));
        check("cyc_instr", instr, expInstr);
        check("cyc_pc_plus4", pc_plus4, pc + 32'd4);
    end

    task automatic setPc(input logic [31:0] v);
        @(posedge clk);
        #1 pc = v;
    endtask

    task automatic measure(output int n);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (!cache_stall) break;
            n++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;

        for (int i = 0; i < MW; i++) img[i] = $urandom;
        img[0]  = 32'h00500093;
        img[1]  = 32'h00a00113;
        img[2]  = 32'h002081b3;
        img[3]  = 32'h00000063;
        img[4]  = 32'h12345678;
        img[16] = 32'hdeadbeef;
        for (int i = 0; i < MW; i++) dut.uMem.mem[i] = img[i];

        @(negedge clk);
        check("rst_stall", 32'(cache_stall), 32'd1);
        check("rst_instr", instr, 32'h00000013);

        @(posedge clk);
        #1 rst = 1'b0;
        measure(n);
        check("lat_first", n, 32'd7);
        check("hit_0x0", instr, 32'h00500093);

        setPc(32'h4);
        @(negedge clk);
        check("hit4_stall", 32'(cache_stall), 32'd0);
        check("hit4_instr", instr, 32'h00a00113);
        setPc(32'h8);
        @(negedge clk);
        check("hit8_stall", 32'(cache_stall), 32'd0);
        check("hit8_instr", instr, 32'h002081b3);
        setPc(32'hC);
        @(negedge clk);
        check("hitC_stall", 32'(cache_stall), 32'd0);
        check("hitC_instr", instr, 32'h00000063);

        setPc(32'h40);
        measure(n);
        check("lat_0x40", n, 32'd7);
        check("hit_0x40", instr, 32'hdeadbeef);
        setPc(32'h0);
        measure(n);
        check("lat_evicted_0x0", n, 32'd7);

        setPc(32'h10);
        repeat (3) @(posedge clk);
        #1 pc = 32'h20;
        measure(n);
        check("lat_redirect", n, 32'd11);
        setPc(32'h10);
        @(negedge clk);
        check("redir_fill_stall", 32'(cache_stall), 32'd0);
        check("redir_fill_instr", instr, 32'h12345678);

        setPc(32'h30);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        measure(n);
        check("lat_after_rst", n, 32'd7);
        setPc(32'h10);
        @(negedge clk);
        check("rst_cleared_0x10", 32'(cache_stall), 32'd1);
        setPc(32'h0);
        @(negedge clk);
        check("rst_cleared_0x0", 32'(cache_stall), 32'd1);

        setPc(32'hFFFFFFFC);
        @(negedge clk);
        check("pc4_wrap", pc_plus4, 32'h00000000);
        setPc(32'h100);
        @(negedge clk);
        check("pc4_0x100", pc_plus4, 32'h00000104);

        @(posedge clk);
        #1 rst = 1'b1;
        pc = 32'h200;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        measure(n);
        check("b2b_idx0", n, 32'd7);
        setPc(32'h210);
        measure(n);
        check("b2b_idx1", n, 32'd7);
        setPc(32'h220);
        measure(n);
        check("b2b_idx2", n, 32'd7);
        setPc(32'h230);
        measure(n);
        check("b2b_idx3", n, 32'd7);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
            end else begin
                r = $urandom_range(0, 15);
                if (!cache_stall) begin
                    if (r < 10) pc = pc + 32'd4;
                    else pc = randPc();
                end else if (r == 0) begin
                    pc = randPc();
                end
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
